// File: rtl/mw8080_video_scan_if.sv
// mw8080_video_scan_if: bundle between the raster scanner and its RAM/video/CPU neighbours.
// Signals:
//   Pix_Ce    pixel-rate clock enable into the scanner
//   Vid_Rd    RAM read strobe, Vid_Addr is the RAM address for that Clock
//   Vid_Data  RAM read data, valid on the Clock edge after Vid_Rd
//   Pixel, HSync_n, VSync_n, HBlank, VBlank  video outputs
//   Irq_Req, Irq_Vec  one-Clock interrupt request and its RST opcode
//   Hcnt, Vcnt  current raster position
//   Flip      cocktail-flip request, present only with MW8080_VIDEO_FLIP_EN
// master: the scanner side; slave: the surrounding system side.
interface mw8080_video_scan_if;
    logic        Pix_Ce;
    logic        Vid_Rd;
    logic [12:0] Vid_Addr;
    logic [7:0]  Vid_Data;
    logic        Pixel;
    logic        HSync_n;
    logic        VSync_n;
    logic        HBlank;
    logic        VBlank;
    logic        Irq_Req;
    logic [7:0]  Irq_Vec;
    logic [8:0]  Hcnt;
    logic [8:0]  Vcnt;
`ifdef MW8080_VIDEO_FLIP_EN
    logic        Flip;
    modport master (input Pix_Ce, Vid_Data, Flip,
                    output Vid_Rd, Vid_Addr, Pixel, HSync_n, VSync_n, HBlank, VBlank,
                           Irq_Req, Irq_Vec, Hcnt, Vcnt);
    modport slave  (output Pix_Ce, Vid_Data, Flip,
                    input Vid_Rd, Vid_Addr, Pixel, HSync_n, VSync_n, HBlank, VBlank,
                          Irq_Req, Irq_Vec, Hcnt, Vcnt);
`else
    modport master (input Pix_Ce, Vid_Data,
                    output Vid_Rd, Vid_Addr, Pixel, HSync_n, VSync_n, HBlank, VBlank,
                           Irq_Req, Irq_Vec, Hcnt, Vcnt);
    modport slave  (output Pix_Ce, Vid_Data,
                    input Vid_Rd, Vid_Addr, Pixel, HSync_n, VSync_n, HBlank, VBlank,
                          Irq_Req, Irq_Vec, Hcnt, Vcnt);
`endif
endinterface

// File: rtl/mw8080_video_scan.sv
// mw8080_video_scan: raster timing, bitmap fetch, pixel serialiser and frame interrupts.
// Ports:
//   Clock_i    system clock
//   Reset_n_i  synchronous reset, active-low
//   bus        mw8080_video_scan_if.master (Pix_Ce, RAM read port, video, IRQ, counters)
// Optional: define MW8080_VIDEO_FLIP_EN to add bus.Flip (cocktail-mode rotation).
module mw8080_video_scan #(
    parameter int          H_TOTAL      = 320,
    parameter int          V_TOTAL      = 262,
    parameter logic [12:0] VRAM_BASE    = 13'h0400,
    parameter int          IRQ_MID_LINE = 96
) (
    input  logic                Clock_i,
    input  logic                Reset_n_i,
    mw8080_video_scan_if.master bus
);
    localparam logic [8:0] H_LAST  = 9'(H_TOTAL - 1);
    localparam logic [8:0] H_PRE   = 9'(H_TOTAL - 2);
    localparam logic [8:0] V_LAST  = 9'(V_TOTAL - 1);
    localparam logic [8:0] IRQ_MID = 9'(IRQ_MID_LINE);

    logic [8:0]  hcnt_q, hcnt_d, vcnt_q, vcnt_d, vnext, fl;
    logic [7:0]  shift_q, shift_d, hold_q, hold_d, vec_q, vec_d, fline;
    logic [12:0] addr_q, addr_d;
    logic [4:0]  fc, fcol;
    logic        hwrap, fetch, flip;
    logic        rd_q, rd_d, pend_q, pend_d, irq_q, irq_d;
    logic        hs_q, hs_d, vs_q, vs_d, hb_q, hb_d, vb_q, vb_d;

`ifdef MW8080_VIDEO_FLIP_EN
    logic flip_q, flip_d;
    // Orientation is latched once per frame so a mid-frame toggle cannot tear the picture.
    assign flip_d = (bus.Pix_Ce && hcnt_q == 9'd0 && vcnt_q == 9'd0) ? bus.Flip : flip_q;
    always_ff @(posedge Clock_i)
        flip_q <= !Reset_n_i ? 1'b0 : flip_d;
    assign flip = flip_q;
`else
    assign flip = 1'b0;
`endif

    always_comb begin
        hwrap   = hcnt_q == H_LAST;
        vnext   = (vcnt_q == V_LAST) ? 9'd0 : vcnt_q + 9'd1;
        hcnt_d  = bus.Pix_Ce ? (hwrap ? 9'd0 : hcnt_q + 9'd1) : hcnt_q;
        vcnt_d  = (bus.Pix_Ce && hwrap) ? vnext : vcnt_q;
        // The fetch at H_PRE prefetches column 0 of the next line; all others fetch the next column.
        fl      = (hcnt_q == H_PRE) ? vnext : vcnt_q;
        fc      = (hcnt_q == H_PRE) ? 5'd0 : hcnt_q[7:3] + 5'd1;
        fetch   = bus.Pix_Ce && hcnt_q[2:0] == 3'd6 && (hcnt_q <= 9'd246 || hcnt_q == H_PRE) && fl < 9'd224;
        fline   = flip ? 8'd223 - fl[7:0] : fl[7:0];
        fcol    = flip ? ~fc : fc;
        rd_d    = fetch;
        addr_d  = fetch ? VRAM_BASE + {fline, fcol} : addr_q;
        pend_d  = bus.Pix_Ce ? fetch : pend_q;
        hold_d  = rd_q ? bus.Vid_Data : hold_q;
        shift_d = !bus.Pix_Ce ? shift_q :
                  (hcnt_q[2:0] == 3'd7 && pend_q) ? hold_q :
                  flip ? {shift_q[6:0], 1'b0} : {1'b0, shift_q[7:1]};
        // Sync/blank decode the upcoming count so they stay aligned with Hcnt/Vcnt.
        hs_d    = !(hcnt_d >= 9'd272 && hcnt_d <= 9'd303);
        vs_d    = !(vcnt_d >= 9'd234 && vcnt_d <= 9'd237);
        hb_d    = hcnt_d >= 9'd256;
        vb_d    = vcnt_d >= 9'd224;
        irq_d   = bus.Pix_Ce && hwrap && (vcnt_d == IRQ_MID || vcnt_d == 9'd224);
        vec_d   = irq_d ? ((vcnt_d == 9'd224) ? 8'hD7 : 8'hCF) : vec_q;
    end

    always_ff @(posedge Clock_i) begin
        if (!Reset_n_i) begin
            hcnt_q  <= 9'd0;
            vcnt_q  <= 9'd0;
            shift_q <= 8'd0;
            hold_q  <= 8'd0;
            addr_q  <= VRAM_BASE;
            rd_q    <= 1'b0;
            pend_q  <= 1'b0;
            irq_q   <= 1'b0;
            vec_q   <= 8'hCF;
            hs_q    <= 1'b1;
            vs_q    <= 1'b1;
            hb_q    <= 1'b0;
            vb_q    <= 1'b0;
        end else begin
            hcnt_q  <= hcnt_d;
            vcnt_q  <= vcnt_d;
            shift_q <= shift_d;
            hold_q  <= hold_d;
            addr_q  <= addr_d;
            rd_q    <= rd_d;
            pend_q  <= pend_d;
            irq_q   <= irq_d;
            vec_q   <= vec_d;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            hb_q    <= hb_d;
            vb_q    <= vb_d;
        end
    end

    assign bus.Vid_Rd   = rd_q;
    assign bus.Vid_Addr = addr_q;
    assign bus.Pixel    = (flip ? shift_q[7] : shift_q[0]) & ~hb_q & ~vb_q;
    assign bus.HSync_n  = hs_q;
    assign bus.VSync_n  = vs_q;
    assign bus.HBlank   = hb_q;
    assign bus.VBlank   = vb_q;
    assign bus.Irq_Req  = irq_q;
    assign bus.Irq_Vec  = vec_q;
    assign bus.Hcnt     = hcnt_q;
    assign bus.Vcnt     = vcnt_q;
endmodule

// File: tb/tb_mw8080_video_scan.sv
// tb_mw8080_video_scan: reset table, randomized raster run against a position-based model.
module tb_mw8080_video_scan;
    localparam int FRAME = 320 * 262;

    typedef struct packed {
        logic        rst;
        logic        ce;
        logic [8:0]  h;
        logic        rd;
        logic [12:0] addr;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mw8080_video_scan_if vif();
    mw8080_video_scan dut (.Clock_i(clk), .Reset_n_i(rst_n), .bus(vif.master));

    logic [7:0] mem [0:8191];
    assign vif.Vid_Data = mem[vif.Vid_Addr];
`ifdef MW8080_VIDEO_FLIP_EN
    assign vif.Flip = 1'b0;
`endif

    int          mh, mv, checks, errors, rd_cnt, irq_cnt;
    bit          col0_ok, e_rd, e_irq;
    logic [12:0] e_addr;
    logic [7:0]  e_vec, line1_bits;
    vec_t        tbl [18];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (model v=%0d h=%0d, t=%0t)", name, act, exp, mv, mh, $time);
        end
    endtask

    // One Clock: drive inputs, advance the raster model, compare every output.
    task automatic step(input bit ce, input bit rst);
        int p, fv, fh;
        logic [7:0] b;
        @(negedge clk);
        vif.Pix_Ce = ce;
        rst_n = !rst;
        @(posedge clk);
        #1;
        e_rd = 1'b0;
        e_irq = 1'b0;
        if (rst) begin
            mh = 0; mv = 0; col0_ok = 1'b0;
            e_addr = 13'h0400; e_vec = 8'hCF;
        end else if (ce) begin
            // A byte is read two pixels before its first pixel is shown.
            p = (mv * 320 + mh + 2) % FRAME;
            fv = p / 320;
            fh = p % 320;
            if (fh < 256 && fh % 8 == 0 && fv < 224) begin
                e_rd = 1'b1;
                e_addr = 13'(32'h400 + fv * 32 + fh / 8);
            end
            if (mh == 318) col0_ok = 1'b1;
            mh++;
            if (mh == 320) begin
                mh = 0;
                mv = (mv + 1) % 262;
            end
            if (mh == 0 && (mv == 96 || mv == 224)) begin
                e_irq = 1'b1;
                e_vec = (mv == 96) ? 8'hCF : 8'hD7;
            end
        end
        b = mem[13'(32'h400 + mv * 32 + mh / 8)];
        chk("hcnt", 32'(vif.Hcnt), 32'(mh));
        chk("vcnt", 32'(vif.Vcnt), 32'(mv));
        chk("vid_rd", 32'(vif.Vid_Rd), 32'(e_rd));
        chk("vid_addr", 32'(vif.Vid_Addr), 32'(e_addr));
        chk("irq_req", 32'(vif.Irq_Req), 32'(e_irq));
        chk("irq_vec", 32'(vif.Irq_Vec), 32'(e_vec));
        chk("hsync_n", 32'(vif.HSync_n), 32'(!(mh >= 272 && mh <= 303)));
        chk("vsync_n", 32'(vif.VSync_n), 32'(!(mv >= 234 && mv <= 237)));
        chk("hblank", 32'(vif.HBlank), 32'(mh >= 256));
        chk("vblank", 32'(vif.VBlank), 32'(mv >= 224));
        chk("pixel", 32'(vif.Pixel),
            32'((mh < 256 && mv < 224 && (mh >= 8 || col0_ok)) ? b[mh % 8] : 1'b0));
        rd_cnt += int'(vif.Vid_Rd);
        irq_cnt += int'(vif.Irq_Req);
        if (mv == 1 && mh < 8) line1_bits[mh] = vif.Pixel;
    endtask

    initial begin
        int gap;
        checks = 0; errors = 0; rd_cnt = 0; irq_cnt = 0;
        mh = 0; mv = 0; col0_ok = 1'b0;
        e_addr = 13'h0400; e_vec = 8'hCF;
        line1_bits = 8'hFF;
        vif.Pix_Ce = 1'b0;
        for (int i = 0; i < 8192; i++) mem[i] = 8'($urandom);
        mem[13'h0400] = 8'b0000_0101;
        mem[13'h0420] = 8'b0000_0101;
        //          rst   ce    hcnt   rd    addr
        tbl[0]  = {1'b1, 1'b1, 9'd0, 1'b0, 13'h0400};
        tbl[1]  = {1'b1, 1'b0, 9'd0, 1'b0, 13'h0400};
        tbl[2]  = {1'b1, 1'b1, 9'd0, 1'b0, 13'h0400};
        tbl[3]  = {1'b0, 1'b0, 9'd0, 1'b0, 13'h0400};
        tbl[4]  = {1'b0, 1'b1, 9'd1, 1'b0, 13'h0400};
        tbl[5]  = {1'b0, 1'b0, 9'd1, 1'b0, 13'h0400};
        tbl[6]  = {1'b0, 1'b1, 9'd2, 1'b0, 13'h0400};
        tbl[7]  = {1'b0, 1'b0, 9'd2, 1'b0, 13'h0400};
        tbl[8]  = {1'b0, 1'b1, 9'd3, 1'b0, 13'h0400};
        tbl[9]  = {1'b0, 1'b0, 9'd3, 1'b0, 13'h0400};
        tbl[10] = {1'b0, 1'b1, 9'd4, 1'b0, 13'h0400};
        tbl[11] = {1'b0, 1'b0, 9'd4, 1'b0, 13'h0400};
        tbl[12] = {1'b0, 1'b1, 9'd5, 1'b0, 13'h0400};
        tbl[13] = {1'b0, 1'b0, 9'd5, 1'b0, 13'h0400};
        tbl[14] = {1'b0, 1'b1, 9'd6, 1'b0, 13'h0400};
        tbl[15] = {1'b0, 1'b0, 9'd6, 1'b0, 13'h0400};
        tbl[16] = {1'b0, 1'b1, 9'd7, 1'b1, 13'h0401};
        tbl[17] = {1'b0, 1'b0, 9'd7, 1'b0, 13'h0401};
        for (int i = 0; i < 18; i++) begin
            step(tbl[i].ce, tbl[i].rst);
            chk("tbl_hcnt", 32'(vif.Hcnt), 32'(tbl[i].h));
            chk("tbl_vcnt", 32'(vif.Vcnt), 32'd0);
            chk("tbl_rd", 32'(vif.Vid_Rd), 32'(tbl[i].rd));
            chk("tbl_addr", 32'(vif.Vid_Addr), 32'(tbl[i].addr));
            chk("tbl_irq", 32'(vif.Irq_Req), 32'd0);
        end
        // Raster run up to line 100, pixel 150, with irregular Pix_Ce spacing on the first lines.
        while (!(mv == 100 && mh == 150)) begin
            step(1'b1, 1'b0);
            gap = (mv < 2) ? int'($urandom_range(2, 4)) : 2;
            for (int g = 1; g < gap; g++) step(1'b0, 1'b0);
        end
        chk("reads_to_reset", 32'(rd_cnt), 32'd3218);
        chk("irqs_to_reset", 32'(irq_cnt), 32'd1);
        chk("line1_first_byte", 32'(line1_bits), 32'h05);
        // Reset lands on a fetching Pix_Ce; nothing stale may follow.
        step(1'b1, 1'b1);
        chk("rst_hcnt", 32'(vif.Hcnt), 32'd0);
        chk("rst_vcnt", 32'(vif.Vcnt), 32'd0);
        chk("rst_addr", 32'(vif.Vid_Addr), 32'h0400);
        chk("rst_rd", 32'(vif.Vid_Rd), 32'd0);
        chk("rst_pixel", 32'(vif.Pixel), 32'd0);
        rd_cnt = 0;
        irq_cnt = 0;
        step(1'b0, 1'b0);
        chk("post_rst_rd", 32'(vif.Vid_Rd), 32'd0);
        chk("post_rst_irq", 32'(vif.Irq_Req), 32'd0);
        for (int i = 0; i < 700; i++) begin
            step(1'b1, 1'b0);
            step(1'b0, 1'b0);
        end
        chk("reads_after_reset", 32'(rd_cnt), 32'd71);
        chk("irqs_after_reset", 32'(irq_cnt), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
